// File: rtl/wb_stream_checker.sv
// Writeback stream checker: compares core writebacks, in program order, against a loadable
// table of expected values. Define WB_CHECK_FIRST_FAIL_EN to add first-mismatch capture ports.
module wb_stream_checker #(
  parameter  int DATA_W      = 32,
  parameter  int DEPTH       = 64,
  parameter  int TIMEOUT_CYC = 90,
  localparam int ADDR_W      = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              exp_we,
  input  logic [ADDR_W-1:0] exp_addr,
  input  logic [DATA_W-1:0] exp_wdata,
  input  logic [ADDR_W:0]   exp_count,
  input  logic              start,
  input  logic              wb_valid,
  input  logic [DATA_W-1:0] wb_data,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic [ADDR_W:0]   match_cnt,
  output logic [ADDR_W:0]   mismatch_cnt,
  output logic [31:0]       cycle_cnt
`ifdef WB_CHECK_FIRST_FAIL_EN
  ,
  output logic              ff_valid,
  output logic [ADDR_W-1:0] ff_idx,
  output logic [DATA_W-1:0] ff_got,
  output logic [DATA_W-1:0] ff_exp
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0]   DEPTH_C  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] IDX_ONE  = ADDR_W'(1);
  localparam logic [31:0]       LAST_CYC = 32'(TIMEOUT_CYC - 1);

  logic [DATA_W-1:0] r_table [DEPTH];

  state_t            r_state;
  state_t            w_state_next;
  logic [ADDR_W:0]   r_n;
  logic [ADDR_W:0]   w_n_next;
  logic [ADDR_W-1:0] r_idx;
  logic [ADDR_W-1:0] w_idx_next;
  logic [ADDR_W:0]   r_match_cnt;
  logic [ADDR_W:0]   w_match_next;
  logic [ADDR_W:0]   r_mismatch_cnt;
  logic [ADDR_W:0]   w_mismatch_next;
  logic [31:0]       r_cycle_cnt;
  logic [31:0]       w_cycle_next;
  logic              r_busy;
  logic              r_done;
  logic              r_pass;
  logic              w_pass_next;
  logic              r_timeout;
  logic              w_timeout_next;

  logic [ADDR_W:0]   w_n_clamp;
  logic [DATA_W-1:0] w_rd_data;
  logic              w_hit;
  logic              w_last;

`ifdef WB_CHECK_FIRST_FAIL_EN
  logic              r_ff_valid;
  logic              w_ff_valid_next;
  logic [ADDR_W-1:0] r_ff_idx;
  logic [ADDR_W-1:0] w_ff_idx_next;
  logic [DATA_W-1:0] r_ff_got;
  logic [DATA_W-1:0] w_ff_got_next;
  logic [DATA_W-1:0] r_ff_exp;
  logic [DATA_W-1:0] w_ff_exp_next;
`endif

  // Table is deliberately left out of reset so a restart after reset reuses its contents.
  always_ff @(posedge clk) begin
    if (exp_we && (r_state != S_RUN)) begin
      r_table[exp_addr] <= exp_wdata;
    end
  end

  assign w_n_clamp = (exp_count > DEPTH_C) ? DEPTH_C : exp_count;
  assign w_rd_data = r_table[r_idx];
  assign w_hit     = (w_rd_data == wb_data);
  assign w_last    = (({1'b0, r_idx} + CNT_ONE) == r_n);

  always_comb begin
    w_state_next    = r_state;
    w_n_next        = r_n;
    w_idx_next      = r_idx;
    w_match_next    = r_match_cnt;
    w_mismatch_next = r_mismatch_cnt;
    w_cycle_next    = r_cycle_cnt;
    w_pass_next     = r_pass;
    w_timeout_next  = r_timeout;
`ifdef WB_CHECK_FIRST_FAIL_EN
    w_ff_valid_next = r_ff_valid;
    w_ff_idx_next   = r_ff_idx;
    w_ff_got_next   = r_ff_got;
    w_ff_exp_next   = r_ff_exp;
`endif

    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_n_next        = w_n_clamp;
          w_idx_next      = '0;
          w_match_next    = '0;
          w_mismatch_next = '0;
          w_cycle_next    = '0;
          w_timeout_next  = 1'b0;
          w_pass_next     = 1'b0;
`ifdef WB_CHECK_FIRST_FAIL_EN
          w_ff_valid_next = 1'b0;
          w_ff_idx_next   = '0;
          w_ff_got_next   = '0;
          w_ff_exp_next   = '0;
`endif
          // An empty run has nothing to check, so it reports pass without entering RUN.
          if (w_n_clamp == '0) begin
            w_state_next = S_DONE;
            w_pass_next  = 1'b1;
          end else begin
            w_state_next = S_RUN;
          end
        end
      end

      S_RUN: begin
        if (r_cycle_cnt != '1) begin
          w_cycle_next = r_cycle_cnt + 32'd1;
        end
        if (wb_valid) begin
          w_idx_next = r_idx + IDX_ONE;
          if (w_hit) begin
            w_match_next = r_match_cnt + CNT_ONE;
          end else begin
            w_mismatch_next = r_mismatch_cnt + CNT_ONE;
`ifdef WB_CHECK_FIRST_FAIL_EN
            if (!r_ff_valid) begin
              w_ff_valid_next = 1'b1;
              w_ff_idx_next   = r_idx;
              w_ff_got_next   = wb_data;
              w_ff_exp_next   = w_rd_data;
            end
`endif
          end
        end
        // Completion takes priority over a timeout expiring on the same cycle.
        if (wb_valid && w_last) begin
          w_state_next = S_DONE;
          w_pass_next  = (w_mismatch_next == '0);
        end else if (r_cycle_cnt == LAST_CYC) begin
          w_state_next   = S_DONE;
          w_timeout_next = 1'b1;
          w_pass_next    = 1'b0;
        end
      end

      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state        <= S_IDLE;
      r_n            <= '0;
      r_idx          <= '0;
      r_match_cnt    <= '0;
      r_mismatch_cnt <= '0;
      r_cycle_cnt    <= '0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_pass         <= 1'b0;
      r_timeout      <= 1'b0;
    end else begin
      r_state        <= w_state_next;
      r_n            <= w_n_next;
      r_idx          <= w_idx_next;
      r_match_cnt    <= w_match_next;
      r_mismatch_cnt <= w_mismatch_next;
      r_cycle_cnt    <= w_cycle_next;
      r_busy         <= (w_state_next == S_RUN);
      r_done         <= (w_state_next == S_DONE);
      r_pass         <= w_pass_next;
      r_timeout      <= w_timeout_next;
    end
  end

`ifdef WB_CHECK_FIRST_FAIL_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_ff_valid <= 1'b0;
      r_ff_idx   <= '0;
      r_ff_got   <= '0;
      r_ff_exp   <= '0;
    end else begin
      r_ff_valid <= w_ff_valid_next;
      r_ff_idx   <= w_ff_idx_next;
      r_ff_got   <= w_ff_got_next;
      r_ff_exp   <= w_ff_exp_next;
    end
  end

  assign ff_valid = r_ff_valid;
  assign ff_idx   = r_ff_idx;
  assign ff_got   = r_ff_got;
  assign ff_exp   = r_ff_exp;
`endif

  assign busy         = r_busy;
  assign done         = r_done;
  assign pass         = r_pass;
  assign timeout      = r_timeout;
  assign match_cnt    = r_match_cnt;
  assign mismatch_cnt = r_mismatch_cnt;
  assign cycle_cnt    = r_cycle_cnt;

endmodule

// File: tb/tb_wb_stream_checker.sv
// Bench for wb_stream_checker: directed scenarios plus randomized runs scored against
// a run-level model that walks the stimulus list and applies the checker's rules directly.
module tb_wb_stream_checker;

  localparam int DEPTH  = 64;
  localparam int TMO    = 90;
  localparam int NSTIM  = 100;

  logic        clk;
  logic        reset;
  logic        exp_we;
  logic [5:0]  exp_addr;
  logic [31:0] exp_wdata;
  logic [6:0]  exp_count;
  logic        start;
  logic        wb_valid;
  logic [31:0] wb_data;
  logic        busy;
  logic        done;
  logic        pass;
  logic        timeout;
  logic [6:0]  match_cnt;
  logic [6:0]  mismatch_cnt;
  logic [31:0] cycle_cnt;
`ifdef WB_CHECK_FIRST_FAIL_EN
  logic        ff_valid;
  logic [5:0]  ff_idx;
  logic [31:0] ff_got;
  logic [31:0] ff_exp;
`endif

  wb_stream_checker dut (
    .clk          (clk),
    .reset        (reset),
    .exp_we       (exp_we),
    .exp_addr     (exp_addr),
    .exp_wdata    (exp_wdata),
    .exp_count    (exp_count),
    .start        (start),
    .wb_valid     (wb_valid),
    .wb_data      (wb_data),
    .busy         (busy),
    .done         (done),
    .pass         (pass),
    .timeout      (timeout),
    .match_cnt    (match_cnt),
    .mismatch_cnt (mismatch_cnt),
    .cycle_cnt    (cycle_cnt)
`ifdef WB_CHECK_FIRST_FAIL_EN
    ,
    .ff_valid     (ff_valid),
    .ff_idx       (ff_idx),
    .ff_got       (ff_got),
    .ff_exp       (ff_exp)
`endif
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] tab [DEPTH];
  bit          st_valid [NSTIM];
  logic [31:0] st_data  [NSTIM];

  int          m_end;
  int          m_match;
  int          m_mis;
  bit          m_to;
  bit          m_pass;
  bit          m_ffv;
  int          m_ffidx;
  logic [31:0] m_ffgot;
  logic [31:0] m_ffexp;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] expv);
    n_tests++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int addr, input logic [31:0] data);
    exp_we    = 1'b1;
    exp_addr  = 6'(addr);
    exp_wdata = data;
    tick();
    exp_we    = 1'b0;
    tab[addr] = data;
  endtask

  task automatic clear_stim();
    for (int k = 0; k < NSTIM; k++) begin
      st_valid[k] = 1'b0;
      st_data[k]  = $urandom;
    end
  endtask

  task automatic gen_stim(input int pct);
    int ig;
    ig = 0;
    for (int k = 0; k < NSTIM; k++) begin
      st_valid[k] = ($urandom_range(1, 100) <= pct);
      if (st_valid[k] && ig < DEPTH && ($urandom % 8 != 0)) st_data[k] = tab[ig];
      else st_data[k] = $urandom;
      if (st_valid[k]) ig++;
    end
  endtask

  // Expected outcome of one run: walk the per-cycle stimulus, compare valid entries in order,
  // stop when n writebacks are seen or when the 90th RUN cycle ends.
  task automatic model_run(input int cnt);
    int n;
    int idx;
    n       = (cnt > DEPTH) ? DEPTH : cnt;
    idx     = 0;
    m_match = 0;
    m_mis   = 0;
    m_to    = 1'b0;
    m_pass  = 1'b0;
    m_ffv   = 1'b0;
    m_ffidx = 0;
    m_ffgot = '0;
    m_ffexp = '0;
    m_end   = -1;
    if (n == 0) begin
      m_end  = 0;
      m_pass = 1'b1;
    end else begin
      for (int k = 0; k < TMO && m_end < 0; k++) begin
        if (st_valid[k]) begin
          if (st_data[k] == tab[idx]) m_match++;
          else begin
            m_mis++;
            if (!m_ffv) begin
              m_ffv   = 1'b1;
              m_ffidx = idx;
              m_ffgot = st_data[k];
              m_ffexp = tab[idx];
            end
          end
          idx++;
          if (idx == n) begin
            m_end  = k + 1;
            m_pass = (m_mis == 0);
          end
        end
        if (m_end < 0 && k == TMO - 1) begin
          m_end = TMO;
          m_to  = 1'b1;
        end
      end
    end
  endtask

  task automatic do_run(input string name, input int cnt, input bit wild);
    int k;
    model_run(cnt);
    exp_count = 7'(cnt);
    start     = 1'b1;
    tick();
    start = 1'b0;
    check_val({name, ".busy_start"}, busy, (m_end != 0));
    check_val({name, ".done_start"}, done, (m_end == 0));
    k = 0;
    while (!done && k < NSTIM) begin
      wb_valid = st_valid[k];
      wb_data  = st_data[k];
      if (wild) begin
        exp_we    = $urandom_range(0, 1);
        exp_addr  = 6'($urandom_range(0, 3));
        exp_wdata = $urandom;
        start     = ($urandom % 8 == 0);
      end
      tick();
      k++;
    end
    wb_valid = 1'b0;
    exp_we   = 1'b0;
    start    = 1'b0;
    if (!done) check_val({name, ".done_bound"}, 0, 1);
    check_val({name, ".run_cycles"}, k, m_end);
    check_val({name, ".busy"}, busy, 0);
    check_val({name, ".pass"}, pass, m_pass);
    check_val({name, ".timeout"}, timeout, m_to);
    check_val({name, ".match"}, match_cnt, m_match);
    check_val({name, ".mismatch"}, mismatch_cnt, m_mis);
    check_val({name, ".cycle_cnt"}, cycle_cnt, m_end);
`ifdef WB_CHECK_FIRST_FAIL_EN
    check_val({name, ".ff_valid"}, ff_valid, m_ffv);
    if (m_ffv) begin
      check_val({name, ".ff_idx"}, ff_idx, m_ffidx);
      check_val({name, ".ff_got"}, ff_got, m_ffgot);
      check_val({name, ".ff_exp"}, ff_exp, m_ffexp);
    end
`endif
    // DONE must ignore further writebacks and hold every counter.
    wb_valid = 1'b1;
    wb_data  = $urandom;
    tick();
    tick();
    wb_valid = 1'b0;
    check_val({name, ".hold_done"}, done, 1);
    check_val({name, ".hold_match"}, match_cnt, m_match);
    check_val({name, ".hold_mismatch"}, mismatch_cnt, m_mis);
    check_val({name, ".hold_cycle"}, cycle_cnt, m_end);
    $display("[TB] run %s cnt=%0d cycles=%0d match=%0d mismatch=%0d timeout=%0d pass=%0d",
             name, cnt, k, match_cnt, mismatch_cnt, timeout, pass);
  endtask

  task automatic stim_1234(input logic [31:0] second);
    clear_stim();
    st_valid[1] = 1'b1; st_data[1] = 32'd1;
    st_valid[4] = 1'b1; st_data[4] = second;
    st_valid[5] = 1'b1; st_data[5] = 32'd3;
    st_valid[9] = 1'b1; st_data[9] = 32'd4;
  endtask

  initial begin
    reset     = 1'b0;
    exp_we    = 1'b0;
    exp_addr  = '0;
    exp_wdata = '0;
    exp_count = '0;
    start     = 1'b0;
    wb_valid  = 1'b0;
    wb_data   = '0;
    tick();
    tick();
    check_val("rst.busy", busy, 0);
    check_val("rst.done", done, 0);
    check_val("rst.pass", pass, 0);
    check_val("rst.timeout", timeout, 0);
    check_val("rst.match", match_cnt, 0);
    check_val("rst.mismatch", mismatch_cnt, 0);
    check_val("rst.cycle", cycle_cnt, 0);
    reset = 1'b1;
    tick();

    for (int a = 0; a < DEPTH; a++) load(a, $urandom);
    for (int a = 0; a < 4; a++) load(a, 32'(a + 1));

    stim_1234(32'd2);
    do_run("t1_match", 4, 1'b0);
    stim_1234(32'd9);
    do_run("t2_mismatch", 4, 1'b0);

    clear_stim();
    st_valid[3] = 1'b1; st_data[3] = 32'd1;
    st_valid[7] = 1'b1; st_data[7] = 32'd2;
    do_run("t3_timeout", 4, 1'b0);

    clear_stim();
    st_valid[10] = 1'b1; st_data[10] = 32'd1;
    st_valid[20] = 1'b1; st_data[20] = 32'd2;
    st_valid[30] = 1'b1; st_data[30] = 32'd3;
    st_valid[89] = 1'b1; st_data[89] = 32'd4;
    do_run("t4_priority", 4, 1'b0);

    clear_stim();
    do_run("t5_empty", 0, 1'b0);

    // Reset in the middle of a run aborts it with everything cleared.
    exp_count = 7'd4;
    start     = 1'b1;
    tick();
    start    = 1'b0;
    wb_valid = 1'b1;
    wb_data  = 32'd1;
    tick();
    wb_data = 32'd2;
    tick();
    wb_valid = 1'b0;
    check_val("t6.pre_match", match_cnt, 2);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check_val("t6.busy", busy, 0);
    check_val("t6.done", done, 0);
    check_val("t6.match", match_cnt, 0);
    check_val("t6.mismatch", mismatch_cnt, 0);
    check_val("t6.cycle", cycle_cnt, 0);
    stim_1234(32'd2);
    do_run("t6_restart_we", 4, 1'b1);
    do_run("t6_table_kept", 4, 1'b0);

    for (int r = 0; r < 24; r++) begin
      int cnt;
      int sel;
      for (int j = 0; j < int'($urandom_range(0, 3)); j++) load($urandom_range(0, DEPTH - 1), $urandom);
      sel = $urandom % 6;
      if (sel == 0) cnt = 0;
      else if (sel == 1) cnt = DEPTH;
      else if (sel == 2) cnt = $urandom_range(DEPTH + 1, 127);
      else cnt = $urandom_range(1, 20);
      gen_stim($urandom_range(40, 100));
      do_run($sformatf("rnd%0d", r), cnt, ($urandom % 2 == 1));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
